// File: rtl/mem_sb_pkg.sv
// -----------------------------------------------------------------------------
// mem_sb_pkg
// Shared constants and the entry record for the MEM-stage store buffer.
//   SB_DEPTH   : default number of buffered stores (power of two, >= 2)
//   SB_PTR_W   : head/tail pointer width for SB_DEPTH entries
//   SB_ADDR_W  : byte-address width
//   SB_DATA_W  : data word width
//   sb_entry_t : {valid, word address, signed data}
// -----------------------------------------------------------------------------
package mem_sb_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_PTR_W  = $clog2(SB_DEPTH);
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  // Only the word index is kept; byte offset bits are dropped because the
  // memory is word addressed.
  typedef struct packed {
    logic                        valid;
    logic [SB_ADDR_W-3:0]        waddr;
    logic signed [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/mem_store_buffer_chk.sv
// -----------------------------------------------------------------------------
// mem_store_buffer_chk
// Property checks on the store buffer's pipeline interface.
// Ports:
//   clk, rst_n : clock and async active-low reset
//   MemRead    : MEM-stage load request
//   MemWrite   : MEM-stage store request
// -----------------------------------------------------------------------------
module mem_store_buffer_chk (
  input logic clk,
  input logic rst_n,
  input logic MemRead,
  input logic MemWrite
);

  // A simultaneous load and store is treated as a store only, but the
  // pipeline should never issue it.
  a_no_read_and_write: assert property (
    @(posedge clk) disable iff (!rst_n) !(MemRead && MemWrite)
  );

endmodule

// File: rtl/store_buffer_match.sv
// -----------------------------------------------------------------------------
// store_buffer_match
// Combinational youngest-first search of the store buffer for a load word.
// Ports:
//   i_entries  : buffer entry array (circular, oldest at i_head)
//   i_head     : index of the oldest entry
//   i_count    : number of occupied entries
//   i_waddr    : word index of the load
//   o_hit      : at least one live entry matches
//   o_hit_data : data of the youngest matching entry
// -----------------------------------------------------------------------------
module store_buffer_match
  import mem_sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0]        i_entries,
  input  logic [PTR_W-1:0]             i_head,
  input  logic [PTR_W:0]               i_count,
  input  logic [SB_ADDR_W-3:0]         i_waddr,
  output logic                         o_hit,
  output logic signed [SB_DATA_W-1:0]  o_hit_data
);

  logic [PTR_W-1:0] w_idx;

  // Walk from oldest to youngest; a later match overwrites an earlier one,
  // so the result is the entry closest to tail.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = {SB_DATA_W{1'b0}};
    w_idx      = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = i_head + PTR_W'(i);
      if (((PTR_W+1)'(i) < i_count) && i_entries[w_idx].valid &&
          (i_entries[w_idx].waddr == i_waddr)) begin
        o_hit      = 1'b1;
        o_hit_data = i_entries[w_idx].data;
      end else begin
        // slot empty or different word: keep the current result
      end
    end
  end

endmodule

// File: rtl/mem_store_buffer.sv
// -----------------------------------------------------------------------------
// mem_store_buffer
// In-order store buffer between the EX/MEM register and word-addressed data
// memory. Stores are queued and drained one per cycle; loads forward from the
// youngest matching buffered store or read memory in the same cycle.
// Ports:
//   clk, rst_n     : clock, async active-low reset (buffer contents discarded)
//   MemRead        : load request
//   MemWrite       : store request
//   address        : byte address (word index = address[ADDR_W-1:2])
//   WriteData      : store data
//   ReadData       : load result, high-Z when no load
//   stall          : store arrived with buffer full and no drain this cycle
//   sb_empty       : buffer holds no stores
//   mem_ready      : memory accepts a write this cycle
//   mem_MemRead    : memory read strobe (load miss)
//   mem_MemWrite   : memory write strobe (drain)
//   mem_address    : memory address (load address on miss, else head)
//   mem_WriteData  : head entry data
//   mem_ReadData   : combinational memory read data
// -----------------------------------------------------------------------------
module mem_store_buffer
  import mem_sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [ADDR_W-1:0]        address,
  input  logic signed [DATA_W-1:0] WriteData,
  output logic signed [DATA_W-1:0] ReadData,
  output logic                     stall,
  output logic                     sb_empty,
  input  logic                     mem_ready,
  output logic                     mem_MemRead,
  output logic                     mem_MemWrite,
  output logic [ADDR_W-1:0]        mem_address,
  output logic signed [DATA_W-1:0] mem_WriteData,
  input  logic signed [DATA_W-1:0] mem_ReadData
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  sb_entry_t [DEPTH-1:0] r_entries;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [PTR_W:0]        r_count;

  logic                     w_load;
  logic                     w_hit;
  logic signed [DATA_W-1:0] w_hit_data;
  logic                     w_load_miss;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_push;

  store_buffer_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .i_entries  (r_entries),
    .i_head     (r_head),
    .i_count    (r_count),
    .i_waddr    (address[ADDR_W-1:2]),
    .o_hit      (w_hit),
    .o_hit_data (w_hit_data)
  );

  mem_store_buffer_chk u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .MemRead  (MemRead),
    .MemWrite (MemWrite)
  );

  // A store wins over a simultaneous load request.
  assign w_load      = MemRead & ~MemWrite;
  assign w_load_miss = w_load & ~w_hit;
  assign w_full      = (r_count == FULL_COUNT);
  // A load miss owns the memory port, so draining waits a cycle.
  assign w_pop       = (r_count != {(PTR_W+1){1'b0}}) & mem_ready & ~w_load_miss;
  // When full, a same-cycle drain frees the slot the new store takes.
  assign w_push      = MemWrite & (~w_full | w_pop);

  assign stall         = MemWrite & w_full & ~w_pop;
  assign sb_empty      = (r_count == {(PTR_W+1){1'b0}});
  assign mem_MemRead   = w_load_miss;
  assign mem_MemWrite  = w_pop;
  assign mem_address   = w_load_miss ? address : {r_entries[r_head].waddr, 2'b00};
  assign mem_WriteData = r_entries[r_head].data;
  assign ReadData      = w_load ? (w_hit ? w_hit_data : mem_ReadData)
                                : {DATA_W{1'bz}};

  // FIFO state: pop clears the head slot, push fills the tail slot. When both
  // hit the same slot (full buffer), the push assignment comes last and wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entries <= {DEPTH{{1'b0, {(ADDR_W-2){1'b0}}, {DATA_W{1'b0}}}}};
      r_head    <= {PTR_W{1'b0}};
      r_tail    <= {PTR_W{1'b0}};
      r_count   <= {(PTR_W+1){1'b0}};
    end else begin
      if (w_pop) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_entries[r_tail] <= '{valid: 1'b1,
                               waddr: address[ADDR_W-1:2],
                               data:  WriteData};
        r_tail            <= r_tail + PTR_W'(1);
      end
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_mem_store_buffer
// Random and directed stimulus against a queue-based reference of the store
// buffer. The stimulus process pushes the expected per-cycle response into a
// scoreboard queue; a monitor pops and compares a little after each negedge.
// -----------------------------------------------------------------------------
module tb_mem_store_buffer;

  localparam int DEPTH = 4;
  localparam int MEM_WORDS = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] WriteData = 32'h0;
  wire  [31:0] ReadData;
  logic        stall;
  logic        sb_empty;
  logic        mem_ready = 1'b0;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [31:0] mem_address;
  logic [31:0] mem_WriteData;
  logic [31:0] mem_ReadData;

  mem_store_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .address       (address),
    .WriteData     (WriteData),
    .ReadData      (ReadData),
    .stall         (stall),
    .sb_empty      (sb_empty),
    .mem_ready     (mem_ready),
    .mem_MemRead   (mem_MemRead),
    .mem_MemWrite  (mem_MemWrite),
    .mem_address   (mem_address),
    .mem_WriteData (mem_WriteData),
    .mem_ReadData  (mem_ReadData)
  );

  always #5 clk = ~clk;

  // Environment data memory driven by the DUT's port.
  logic [31:0] bmem [0:MEM_WORDS-1];
  assign mem_ReadData = bmem[mem_address[14:2]];
  always @(posedge clk) begin
    if (mem_MemWrite) bmem[mem_address[14:2]] <= mem_WriteData;
  end

  // Reference model: ordered list of pending stores plus its own memory image.
  typedef struct { logic [29:0] w; logic [31:0] d; } st_t;
  st_t         ref_q[$];
  logic [31:0] ref_mem [0:MEM_WORDS-1];

  typedef struct {
    logic        chk_rd;
    logic [31:0] rd;
    logic        mrd;
    logic        mwr;
    logic        chk_addr;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic        stl;
    logic        empty;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One cycle of stimulus: drive at negedge, predict outputs, advance model.
  task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy, input logic rst);
    exp_t        e;
    logic        hit, load, miss, pop;
    logic [31:0] hd;
    @(negedge clk);
    rst_n     = ~rst;
    MemRead   = rd;
    MemWrite  = wr;
    address   = a;
    WriteData = d;
    mem_ready = rdy;
    if (rst) ref_q.delete();
    load = rd & ~wr;
    hit  = 1'b0;
    hd   = 32'h0;
    foreach (ref_q[i]) begin
      if (ref_q[i].w == a[31:2]) begin
        hit = 1'b1;
        hd  = ref_q[i].d;
      end
    end
    miss       = load & ~hit;
    pop        = (ref_q.size() > 0) && rdy && !miss;
    e.chk_rd   = load;
    e.rd       = hit ? hd : ref_mem[a[14:2]];
    e.mrd      = miss;
    e.mwr      = pop;
    e.chk_addr = miss | pop;
    e.maddr    = miss ? a : (pop ? {ref_q[0].w, 2'b00} : 32'h0);
    e.wdata    = pop ? ref_q[0].d : 32'h0;
    e.stl      = wr && (ref_q.size() == DEPTH) && !pop;
    e.empty    = (ref_q.size() == 0);
    exp_q.push_back(e);
    if (!rst) begin
      if (pop) begin
        ref_mem[ref_q[0].w[12:0]] = ref_q[0].d;
        void'(ref_q.pop_front());
      end
      if (wr && !e.stl) ref_q.push_back('{a[31:2], d});
    end
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 32'h0, rdy, 1'b0);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", {31'b0, stall}, {31'b0, e.stl});
        chk("sb_empty", {31'b0, sb_empty}, {31'b0, e.empty});
        chk("mem_MemRead", {31'b0, mem_MemRead}, {31'b0, e.mrd});
        chk("mem_MemWrite", {31'b0, mem_MemWrite}, {31'b0, e.mwr});
        if (e.chk_rd) chk("ReadData", ReadData, e.rd);
        if (e.chk_addr) chk("mem_address", mem_address, e.maddr);
        if (e.mwr) chk("mem_WriteData", mem_WriteData, e.wdata);
      end
    end
  end

  initial begin
    int r;
    logic [31:0] a;
    for (int i = 0; i < MEM_WORDS; i++) begin
      bmem[i]    = (i * 32'h9E37) ^ 32'h5A5A0000;
      ref_mem[i] = (i * 32'h9E37) ^ 32'h5A5A0000;
    end

    // Reset state.
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

    // Single store then drain.
    step(1'b0, 1'b1, 32'h1000, 32'h0000002A, 1'b1, 1'b0);
    idle(1'b1, 3);

    // Three stores to the same word, forwarded load picks the youngest.
    step(1'b0, 1'b1, 32'h2000, 32'd11, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h2000, 32'd22, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h2000, 32'd33, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, 1'b0);
    idle(1'b1, 4);

    // Full buffer: stall, then pop+push with mem_ready.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h2100 + 32'(i * 4), 32'(100 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h3000, 32'd55, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h3000, 32'd55, 1'b1, 1'b0);
    idle(1'b1, 6);

    // Load miss owns the port; drain follows on the next non-load cycle.
    step(1'b0, 1'b1, 32'h4000, 32'd7, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h5000, 32'h0, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Reset in the middle of draining three stores.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h4100 + 32'(i * 4), 32'(200 + i), 1'b0, 1'b0);
    idle(1'b1, 1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    idle(1'b1, 4);

    // Wrap-around: ten sequential stores with interleaved drains.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h6000 + 32'(i * 4), 32'(300 + i), 1'(i % 2), 1'b0);
    idle(1'b1, 8);

    // Random traffic over a small set of words so forwarding hits often.
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 9));
      a = {15'b0, 13'h40 + 13'($urandom_range(0, 11)), 2'($urandom_range(0, 3)), 2'b00} >> 2;
      a = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      end else if (r < 3) begin
        step(1'b0, 1'b0, a, 32'h0, 1'($urandom_range(0, 3) != 0), 1'b0);
      end else if (r < 6) begin
        step(1'b1, 1'b0, a, 32'h0, 1'($urandom_range(0, 3) != 0), 1'b0);
      end else begin
        step(1'b0, 1'b1, a, $urandom, 1'($urandom_range(0, 3) != 0), 1'b0);
      end
    end
    idle(1'b1, 8);

    @(negedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < MEM_WORDS; i++) begin
      if (bmem[i] !== ref_mem[i]) chk("memory_image", bmem[i], ref_mem[i]);
    end
    chk("memory_word_0x1000", bmem[32'h1000 >> 2], 32'h0000002A);
    chk("memory_word_0x4000", bmem[32'h4000 >> 2], 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
- Small in-order store buffer in the MEM stage, between the EX/MEM pipeline register and the word-addressed data memory.
- Accepts stores from the pipeline and drains them to memory one per cycle when the memory port is free.
- Serves loads by forwarding from the youngest matching buffered store, or by reading memory.
- Raises a stall toward the hazard unit when a store arrives with the buffer full.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data word width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- MemRead  in  1  MEM-stage load request.
- MemWrite  in  1  MEM-stage store request.
- address  in  ADDR_W  byte address; word index is address[31:2].
- WriteData  in  DATA_W  store data, signed.
- ReadData  out  DATA_W  load result to MEM/WB; 32'bz when no load.
- stall  out  1  store cannot be accepted this cycle; pipeline holds.
- sb_empty  out  1  no valid entries; used by halt/fence logic.
- mem_ready  in  1  memory accepts a write this cycle; tied 1 for the current single-cycle memory.
- mem_MemRead  out  1  read strobe to data memory.
- mem_MemWrite  out  1  write strobe to data memory.
- mem_address  out  ADDR_W  address to data memory.
- mem_WriteData  out  DATA_W  write data to data memory.
- mem_ReadData  in  DATA_W  combinational read data from data memory.

Behaviour:
- Reset (async, rst_n=0):
  - head, tail and count = 0; all entry valid bits cleared.
  - Outputs: stall=0, sb_empty=1, mem_MemWrite=0, mem_MemRead=0.
  - Buffered stores are discarded on reset mid-operation. This is intentional and is not written back.
- Entry contents: {valid, word address address[31:2], data}. Circular FIFO with head (oldest) and tail (next free). Pointers wrap modulo DEPTH.
- MemRead=1 and MemWrite=1 together is illegal. It is handled as a store only: ReadData=z, and an SVA flags it.
- Load, combinational, same cycle:
  - The word index is compared against all valid entries.
  - Hit: ReadData = data of the youngest matching entry (closest to tail), and mem_MemRead=0.
  - Miss: mem_MemRead=1, mem_address=address, ReadData=mem_ReadData.
  - Loads never stall.
- Drain: pop is true when count>0, mem_ready=1, and there is no load miss this cycle (a load miss owns the memory port).
  - On pop: mem_MemWrite=1, with mem_address={head word index,2'b00} and mem_WriteData=head data.
  - head and count update at posedge.
- Push: push is true when MemWrite=1 and (count<DEPTH or pop).
  - The entry is written at tail at posedge.
  - Push and pop in the same cycle leave count unchanged. This is legal when full.
- stall = MemWrite & (count==DEPTH) & ~pop. Registered state is unchanged while stalled except for a pop.
- Latency: a store pushed at edge N is at the head no earlier than cycle N+1. It reaches memory at the edge ending its drain cycle.
- Ordering: drains are strictly FIFO, so memory sees stores in program order. Stores to the same word are kept, not merged.
- Memory port mux: on a load miss the address is the load address. Otherwise the address is the head address.
- sb_empty = (count==0), combinational from registered state.

Decomposition:
- Package mem_sb_pkg:
  - SB_DEPTH and SB_PTR_W = $clog2(DEPTH) constants.
  - Entry typedef {logic valid; logic [ADDR_W-3:0] waddr; logic signed [DATA_W-1:0] data;}.
- Sub-module store_buffer_match: combinational youngest-first priority search.
  - Inputs: entry array, head, count, load word index.
  - Outputs: hit and hit_data.
- The top level holds the FIFO, counters and port muxing.

Test Plan:
- Reset, then store 0x0000002A to address 0x1000 with mem_ready=1 → pushed; one cycle later mem_MemWrite=1, mem_address=0x1000, mem_WriteData=42; sb_empty returns to 1.
- With mem_ready=0, store 11, 22 and 33 to 0x2000, then load 0x2000 → ReadData=33 (youngest), mem_MemRead=0, no memory access.
- With mem_ready=0, perform 4 stores, then a 5th store to 0x3000 → stall=1 and count stays 4. Raise mem_ready=1 → same-cycle pop+push, stall=0, count stays 4.
- Buffer holds 0x4000=7 and mem_ready=1; a load miss to 0x5000 → mem_MemRead=1, no drain that cycle; drain of 7 occurs on the next non-load cycle.
- Fill 3 entries, assert rst_n=0 mid-drain → sb_empty=1, stall=0, mem_MemWrite=0 immediately; no further writes after release.
- Wrap-around: 10 stores with interleaved drains to sequential addresses → memory receives all 10 in order and head/tail wrap correctly.
